wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
// PURPOSE
// Weighted round-robin arbiter with packet lock for the switch crossbar output stage.
// Each output port has one. It chooses among WIDTH input requesters.
// It holds a grant for a whole packet (up to the tail beat).
// A winner keeps the port for up to weight[i] consecutive packets before rotating.
// It generalises the single-beat round-robin arbiter with weights, packet locking and a one-hot grant.
// PARAMETERS
// WIDTH     4  number of requesters (>=1)
// WEIGHT_W  4  bits per requester weight; weight 0 is treated as 1
// SEL_W     (WIDTH>1)?$clog2(WIDTH):1  select index width (derived, do not override)
// PORTS
// CLK          in   1               clock
// nRST         in   1               async active-low reset
// bid          in   WIDTH           per-requester request, held high until its packet tail transfers
// last         in   WIDTH           per-requester tail flag of the current beat
// weight       in   WIDTH*WEIGHT_W  packets per turn; requester i uses bits [i*WEIGHT_W +: WEIGHT_W]
// ready        in   1               downstream accepts a beat this cycle
// select       out  SEL_W           index of current owner (registered)
// grant        out  WIDTH           one-hot of select when valid, else 0 (registered)
// valid        out  1               an owner exists (registered)
// credits      out  WEIGHT_W        packets remaining in owner's turn (registered)
// BEHAVIOUR
// Reset: select=0, grant=0, valid=0, credits=0, in_pkt=0, state=IDLE. Async assert, sync release.
// xfer = valid & ready & bid[select]. tail = xfer & last[select].
// States:
// - IDLE: valid=0. If |bid, go to OWN in the next cycle.
//   - Winner = first set bid searching select+1 .. WIDTH-1, then 0 .. select (current index has lowest priority).
//   - credits <= max(weight[winner],1).
// - OWN: valid=1.
//   - Non-tail xfer: in_pkt <= 1.
//   - tail: in_pkt <= 0, credits decrements.
//   - Re-arbitrate when (tail & credits==1) or (!in_pkt & !bid[select]).
//     - Same cycle, same rotating search. If a winner is found: select updates next cycle and credits reloads.
//       There is no bubble: handoff adds 0 idle cycles.
//     - No bid present: go to IDLE, valid=0, grant=0, and select keeps its last value (rotation anchor).
//   - Tail with credits>1 and bid[select] still high: keep owner, credits-1.
// Locking:
// - While in_pkt=1, ownership is held even if bid[select] drops. No xfer is counted.
// - A requester never loses the port mid-packet.
// Latency: bid rising in IDLE at cycle N gives valid/grant at N+1.
// Lone requester: wins again with credits reloaded, so it keeps streaming.
// WIDTH=1: select stays 0, rotation degenerates to reload.
// last is ignored unless xfer. ready low freezes credits and in_pkt.
// Reset mid-packet: all state cleared, no partial-packet memory.
// Weight is sampled only at load. Changes mid-turn take effect at the next load.
// STRUCTURE
// switch_pkg: typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t.
// rr_picker (combinational sub-module, reusable):
// - Inputs: req[WIDTH], base[SEL_W].
// - Outputs: found and idx, the first set bit after base with wrap-around; base is checked last.
// Top level holds the state FSM, the credit counter, the in_pkt flag and the output registers.
// TESTING
// 1. Reset, then bid=4'b0101, weights all 1, ready=1, every beat last.
//    -> select is 2, 0, 2, 0 on consecutive cycles, starting one cycle after bid (the rotation anchor is 0).
// 2. weight[0]=3, weight[1]=1, bid=4'b0011 held, single-beat packets.
//    -> owner pattern 0,0,0,1,0,0,0,1; credits shows 3,2,1,1.
// 3. Requester 1 sends a 4-beat packet, last on beat 4, while bid[3] rises at beat 2.
//    -> select=1 until the tail; select=3 on the next cycle with no idle cycle.
// 4. Mid-packet: ready=0 for 3 cycles and bid[1] low for 1 cycle.
//    -> grant stays 4'b0010, credits and in_pkt unchanged, no ownership loss.
// 5. Only bid[2] with weight 0.
//    -> treated as 1: credits=1 reloads every tail and valid stays 1.
//    -> when bid drops after the tail, the next cycle has valid=0, grant=0, select=2.
// 6. Assert nRST low mid-packet with owner 3.
//    -> immediately valid=0, grant=0, select=0. After release, bid=4'b1000 wins 3 again one cycle later.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types for the switch output-stage arbitration logic.
package switch_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority search: first set request after base, wrapping round, base checked last.
module rr_picker #(
  parameter int WIDTH = 4,
  parameter int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [SEL_W-1:0] base,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic             hi_found;
  logic [SEL_W-1:0] hi_idx;
  logic             lo_found;
  logic [SEL_W-1:0] lo_idx;

  // Descending scans so the lowest qualifying index is the last one written.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(base))) begin
        hi_found = 1'b1;
        hi_idx   = SEL_W'(i);
      end
      if (req[i] && (i <= int'(base))) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
      end
    end
    found = hi_found | lo_found;
    idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with packet lock for one crossbar output port.
// Valid/ready: a beat of the owner moves when valid & ready & bid[select]; last marks its tail.
module wrr_arbiter
  import switch_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4,
  parameter int SEL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [WIDTH-1:0]          bid,
  input  logic [WIDTH-1:0]          last,
  input  logic [WIDTH*WEIGHT_W-1:0] weight,
  input  logic                      ready,
  output logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          grant,
  output logic                      valid,
  output logic [WEIGHT_W-1:0]       credits,
  output arb_state_t                dbg_state,
  output logic                      dbg_in_pkt
);

  arb_state_t          state_q, state_d;
  logic [SEL_W-1:0]    select_q, select_d;
  logic [WIDTH-1:0]    grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [WEIGHT_W-1:0] credits_q, credits_d;
  logic                in_pkt_q, in_pkt_d;

  logic                pick_found;
  logic [SEL_W-1:0]    pick_idx;
  logic [WEIGHT_W-1:0] pick_weight;
  logic [WEIGHT_W-1:0] load_credits;
  logic [WIDTH-1:0]    pick_onehot;
  logic                xfer;
  logic                tail;
  logic                rearb;

  rr_picker #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_picker (
    .req   (bid),
    .base  (select_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A zero weight would starve the winner, so it counts as one packet.
  always_comb begin
    pick_weight = '0;
    pick_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (SEL_W'(i) == pick_idx) begin
        pick_weight    = weight[i*WEIGHT_W +: WEIGHT_W];
        pick_onehot[i] = 1'b1;
      end
    end
    load_credits = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
  end

  assign xfer  = valid_q & ready & bid[select_q];
  assign tail  = xfer & last[select_q];
  assign rearb = (tail & (credits_q == WEIGHT_W'(1))) | (~in_pkt_q & ~bid[select_q]);

  always_comb begin
    state_d   = state_q;
    select_d  = select_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    credits_d = credits_q;
    in_pkt_d  = in_pkt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d   = ARB_OWN;
          select_d  = pick_idx;
          grant_d   = pick_onehot;
          valid_d   = 1'b1;
          credits_d = load_credits;
          in_pkt_d  = 1'b0;
        end
      end
      ARB_OWN: begin
        if (rearb) begin
          if (pick_found) begin
            select_d  = pick_idx;
            grant_d   = pick_onehot;
            credits_d = load_credits;
            in_pkt_d  = 1'b0;
          end else begin
            // select is left alone so the next search rotates from here.
            state_d   = ARB_IDLE;
            grant_d   = '0;
            valid_d   = 1'b0;
            credits_d = '0;
            in_pkt_d  = 1'b0;
          end
        end else if (tail) begin
          credits_d = credits_q - WEIGHT_W'(1);
          in_pkt_d  = 1'b0;
        end else if (xfer) begin
          in_pkt_d  = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ARB_IDLE;
      select_q  <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      credits_q <= '0;
      in_pkt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      credits_q <= credits_d;
      in_pkt_q  <= in_pkt_d;
    end
  end

  assign select     = select_q;
  assign grant      = grant_q;
  assign valid      = valid_q;
  assign credits    = credits_q;
  assign dbg_state  = state_q;
  assign dbg_in_pkt = in_pkt_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: rotation, weights, packet lock, stalls, weight zero, reset.
module tb_wrr_arbiter;
  import switch_pkg::*;

  logic        CLK;
  logic        nRST;
  logic [3:0]  bid;
  logic [3:0]  last;
  logic [15:0] weight;
  logic        ready;
  logic [1:0]  select;
  logic [3:0]  grant;
  logic        valid;
  logic [3:0]  credits;
  arb_state_t  dbg_state;
  logic        dbg_in_pkt;

  int n_cmp;
  int n_err;

  wrr_arbiter #(.WIDTH(4), .WEIGHT_W(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bid        (bid),
    .last       (last),
    .weight     (weight),
    .ready      (ready),
    .select     (select),
    .grant      (grant),
    .valid      (valid),
    .credits    (credits),
    .dbg_state  (dbg_state),
    .dbg_in_pkt (dbg_in_pkt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Clears inputs, pulses reset and releases it on a falling edge.
  task automatic do_reset();
    bid    = 4'b0000;
    last   = 4'b0000;
    ready  = 1'b1;
    weight = 16'h1111;
    nRST   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({valid, grant, select, credits, dbg_in_pkt} !== 12'b0 || dbg_state !== ARB_IDLE) begin
      n_err++;
      $display("FAIL reset_vals got v=%b g=%b s=%0d c=%0d p=%b st=%0d exp all zero/IDLE",
               valid, grant, select, credits, dbg_in_pkt, dbg_state);
    end
    step();
    n_cmp++;
    if (valid !== 1'b0 || grant !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_nobid got v=%b g=%b exp v=0 g=0000", valid, grant);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel [4];
    logic [3:0] exp_gnt [4];
    exp_sel = '{2'd2, 2'd0, 2'd2, 2'd0};
    exp_gnt = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    do_reset();
    bid  = 4'b0101;
    last = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (select !== exp_sel[c] || grant !== exp_gnt[c] || valid !== 1'b1) begin
        n_err++;
        $display("FAIL rotation cyc%0d got s=%0d g=%b v=%b exp s=%0d g=%b v=1",
                 c, select, grant, valid, exp_sel[c], exp_gnt[c]);
      end
    end
  endtask

  task automatic test_weights();
    logic [1:0] exp_sel [9];
    logic [3:0] exp_cr  [9];
    exp_sel = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    exp_cr  = '{4'd1, 4'd3, 4'd2, 4'd1, 4'd1, 4'd3, 4'd2, 4'd1, 4'd1};
    do_reset();
    weight = 16'h1113;
    bid    = 4'b0011;
    last   = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      step();
      n_cmp++;
      if (select !== exp_sel[c] || credits !== exp_cr[c] || valid !== 1'b1) begin
        n_err++;
        $display("FAIL weights cyc%0d got s=%0d c=%0d v=%b exp s=%0d c=%0d v=1",
                 c, select, credits, valid, exp_sel[c], exp_cr[c]);
      end
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    bid  = 4'b0010;
    last = 4'b0000;
    step();
    for (int b = 1; b <= 3; b++) begin
      n_cmp++;
      if (select !== 2'd1 || grant !== 4'b0010 || valid !== 1'b1) begin
        n_err++;
        $display("FAIL lock_beat%0d got s=%0d g=%b v=%b exp s=1 g=0010 v=1", b, select, grant, valid);
      end
      if (b == 2) bid = 4'b1010;
      step();
    end
    last = 4'b0010;
    n_cmp++;
    if (select !== 2'd1 || dbg_in_pkt !== 1'b1) begin
      n_err++;
      $display("FAIL lock_beat4 got s=%0d p=%b exp s=1 p=1", select, dbg_in_pkt);
    end
    step();
    bid  = 4'b1000;
    last = 4'b0000;
    n_cmp++;
    if (select !== 2'd3 || grant !== 4'b1000 || valid !== 1'b1) begin
      n_err++;
      $display("FAIL lock_handoff got s=%0d g=%b v=%b exp s=3 g=1000 v=1", select, grant, valid);
    end
  endtask

  task automatic test_stall();
    logic [3:0] stall_bid [3];
    stall_bid = '{4'b0010, 4'b0000, 4'b0010};
    do_reset();
    weight = 16'h1131;
    bid    = 4'b0010;
    last   = 4'b0000;
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      ready = 1'b0;
      bid   = stall_bid[c];
      step();
      n_cmp++;
      if (grant !== 4'b0010 || credits !== 4'd3 || dbg_in_pkt !== 1'b1 || valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall cyc%0d got g=%b c=%0d p=%b v=%b exp g=0010 c=3 p=1 v=1",
                 c, grant, credits, dbg_in_pkt, valid);
      end
    end
    ready = 1'b1;
    bid   = 4'b0010;
    last  = 4'b0010;
    step();
    n_cmp++;
    if (grant !== 4'b0010 || credits !== 4'd2 || dbg_in_pkt !== 1'b0) begin
      n_err++;
      $display("FAIL stall_tail got g=%b c=%0d p=%b exp g=0010 c=2 p=0", grant, credits, dbg_in_pkt);
    end
    bid  = 4'b0000;
    last = 4'b0000;
    step();
    n_cmp++;
    if (valid !== 1'b0 || grant !== 4'b0000 || select !== 2'd1) begin
      n_err++;
      $display("FAIL stall_release got v=%b g=%b s=%0d exp v=0 g=0000 s=1", valid, grant, select);
    end
  endtask

  task automatic test_weight_zero();
    do_reset();
    weight = 16'h1011;
    bid    = 4'b0100;
    last   = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (select !== 2'd2 || credits !== 4'd1 || valid !== 1'b1) begin
        n_err++;
        $display("FAIL wzero cyc%0d got s=%0d c=%0d v=%b exp s=2 c=1 v=1", c, select, credits, valid);
      end
    end
    bid = 4'b0000;
    step();
    n_cmp++;
    if (valid !== 1'b0 || grant !== 4'b0000 || select !== 2'd2) begin
      n_err++;
      $display("FAIL wzero_drop got v=%b g=%b s=%0d exp v=0 g=0000 s=2", valid, grant, select);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bid  = 4'b1000;
    last = 4'b0000;
    step();
    step();
    n_cmp++;
    if (select !== 2'd3 || dbg_in_pkt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre got s=%0d p=%b exp s=3 p=1", select, dbg_in_pkt);
    end
    nRST = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || grant !== 4'b0000 || select !== 2'd0 || dbg_in_pkt !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async got v=%b g=%b s=%0d p=%b exp v=0 g=0000 s=0 p=0",
               valid, grant, select, dbg_in_pkt);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
    n_cmp++;
    if (valid !== 1'b1 || grant !== 4'b1000 || select !== 2'd3 || dbg_in_pkt !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_rewin got v=%b g=%b s=%0d p=%b exp v=1 g=1000 s=3 p=0",
               valid, grant, select, dbg_in_pkt);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    nRST   = 1'b0;
    bid    = 4'b0000;
    last   = 4'b0000;
    weight = 16'h1111;
    ready  = 1'b1;
    test_reset();
    test_rotation();
    test_weights();
    test_packet_lock();
    test_stall();
    test_weight_zero();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
